// File: rtl/gcd_pkg.sv
// Shared types and defaults for the round-robin gcd scheduler.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        RESP
    } state_t;

    localparam int unsigned DEF_N_REQ   = 4;
    localparam int unsigned DEF_WIDTH   = 16;
    localparam int unsigned DEF_TIMEOUT = 1023;

    // Requester-index width; a single requester bit is kept even for N_REQ<=2.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr, with wrap.
module gcd_rr_arbiter
    import gcd_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]           req,
    input  logic [id_width(N_REQ)-1:0] rr_ptr,
    input  logic                       enable,
    output logic [N_REQ-1:0]           grant,
    output logic [id_width(N_REQ)-1:0] idx
);

    localparam int unsigned IDW = id_width(N_REQ);

    always_comb begin
        logic [IDW-1:0] j;
        logic           found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j = IDW'((32'(rr_ptr) + i) % N_REQ);
            if (enable && !found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/gcd_scheduler.sv
// Shares one subtractive-Euclid gcd datapath between N_REQ requesters,
// with an a==0 bypass and a bounded wait that aborts with an error flag.
module gcd_scheduler
    import gcd_pkg::*;
#(
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           io_req_valid,
    output logic [N_REQ-1:0]           io_req_ready,
    input  logic [N_REQ*WIDTH-1:0]     io_req_value1,
    input  logic [N_REQ*WIDTH-1:0]     io_req_value2,
    output logic                       io_resp_valid,
    input  logic                       io_resp_ready,
    output logic [id_width(N_REQ)-1:0] io_resp_id,
    output logic [WIDTH-1:0]           io_resp_gcd,
    output logic                       io_resp_err,
    output logic [WIDTH-1:0]           io_gcd_value1,
    output logic [WIDTH-1:0]           io_gcd_value2,
    output logic                       io_gcd_loadingValues,
    input  logic [WIDTH-1:0]           io_gcd_outputGCD,
    input  logic                       io_gcd_outputValid
);

    localparam int unsigned IDW = id_width(N_REQ);
    localparam int unsigned CW  = $clog2(TIMEOUT + 1);

    state_t           state, state_next;
    logic [IDW-1:0]   rr_ptr, id_q, grant_idx;
    logic [WIDTH-1:0] a_q, b_q, gcd_q, req_a, req_b;
    logic             err_q, grant_any, timeout_hit;
    logic [CW-1:0]    cnt;
    logic [N_REQ-1:0] grant;

    gcd_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req    (io_req_valid),
        .rr_ptr (rr_ptr),
        .enable ((state == IDLE) && !reset),
        .grant  (grant),
        .idx    (grant_idx)
    );

    assign grant_any   = |grant;
    assign req_a       = io_req_value1[32'(grant_idx)*WIDTH +: WIDTH];
    assign req_b       = io_req_value2[32'(grant_idx)*WIDTH +: WIDTH];
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    assign io_req_ready  = grant;
    assign io_resp_id    = id_q;
    assign io_resp_gcd   = gcd_q;
    assign io_resp_err   = err_q;
    assign io_gcd_value1 = a_q;
    assign io_gcd_value2 = b_q;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // outputValid is ignored in LOAD: the datapath still shows the previous job's valid there.
    always_comb begin
        state_next           = state;
        io_gcd_loadingValues = 1'b0;
        io_resp_valid        = 1'b0;
        case (state)
            IDLE: if (grant_any) state_next = (req_a == '0) ? RESP : LOAD;
            LOAD: begin
                io_gcd_loadingValues = 1'b1;
                state_next           = WAIT;
            end
            WAIT: if (io_gcd_outputValid || timeout_hit) state_next = RESP;
            RESP: begin
                io_resp_valid = 1'b1;
                if (io_resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            gcd_q  <= '0;
            err_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (grant_any) begin
                    a_q    <= req_a;
                    b_q    <= req_b;
                    id_q   <= grant_idx;
                    rr_ptr <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    // Preloaded as the bypass result; overwritten by the datapath otherwise.
                    gcd_q  <= req_b;
                    err_q  <= 1'b0;
                    cnt    <= '0;
                end
                LOAD: cnt <= '0;
                WAIT: begin
                    if (io_gcd_outputValid) begin
                        gcd_q <= io_gcd_outputGCD;
                        err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        gcd_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_scheduler.sv
// Randomized self-checking bench for gcd_scheduler with a Chisel-style gcd datapath model.
module tb_gcd_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 16;
    localparam int unsigned TO = 8;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] v1, v2;
    logic           resp_valid, resp_ready, resp_err;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_gcd, gcd_v1, gcd_v2, out_gcd;
    logic           loading, out_valid, stall;
    logic [W-1:0]   dx, dy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    gcd_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clock                (clock),
        .reset                (reset),
        .io_req_valid         (req_valid),
        .io_req_ready         (req_ready),
        .io_req_value1        (v1),
        .io_req_value2        (v2),
        .io_resp_valid        (resp_valid),
        .io_resp_ready        (resp_ready),
        .io_resp_id           (resp_id),
        .io_resp_gcd          (resp_gcd),
        .io_resp_err          (resp_err),
        .io_gcd_value1        (gcd_v1),
        .io_gcd_value2        (gcd_v2),
        .io_gcd_loadingValues (loading),
        .io_gcd_outputGCD     (out_gcd),
        .io_gcd_outputValid   (out_valid)
    );

    // Chisel GCD datapath; stall hides outputValid to provoke the timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            dx <= '0;
            dy <= '0;
        end else if (loading) begin
            dx <= gcd_v1;
            dy <= gcd_v2;
        end else if (dx > dy) begin
            dx <= dx - dy;
        end else begin
            dy <= dy - dx;
        end
    end
    assign out_gcd   = dx;
    assign out_valid = (dy == '0) && !stall;

    function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Expected result and cycle of resp_valid (grant cycle = 0).
    function automatic void ref_model(input int unsigned a, input int unsigned b,
                                      output int unsigned g, output logic e,
                                      output int lat, output int loads);
        int unsigned x, y;
        int k;
        x = a;
        y = b;
        k = 0;
        if (a == 0) begin
            g = b; e = 1'b0; lat = 1; loads = 0;
            return;
        end
        while (y != 0 && k < int'(TO)) begin
            if (x > y) x = x - y;
            else       y = y - x;
            k++;
        end
        loads = 1;
        if (y == 0 && k < int'(TO)) begin
            g = ref_gcd(a, b); e = 1'b0; lat = 3 + k;
        end else begin
            g = 0; e = 1'b1; lat = 2 + int'(TO);
        end
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        stall      = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Issues one request from an idle scheduler and records what the DUT does.
    task automatic do_job(input int idx, input int unsigned a, input int unsigned b,
                          output logic [N-1:0] g, output int lat, output int loads,
                          output logic [1:0] id, output logic [W-1:0] r, output logic e);
        @(negedge clock);
        resp_ready         = 1'b1;
        v1[idx*W +: W]     = W'(a);
        v2[idx*W +: W]     = W'(b);
        req_valid[idx]     = 1'b1;
        #1 g = req_ready;
        @(posedge clock);
        #1 req_valid[idx] = 1'b0;
        lat   = 0;
        loads = 0;
        while (lat < 300) begin
            @(negedge clock);
            lat++;
            if (loading) loads++;
            if (resp_valid) break;
        end
        id = resp_id;
        r  = resp_gcd;
        e  = resp_err;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
        checks++; if (loading !== 1'b0) begin errors++; $display("FAIL reset_loading got %b exp 0", loading); end
        checks++; if ({resp_id, resp_gcd, resp_err, gcd_v1, gcd_v2} !== '0) begin
            errors++; $display("FAIL reset_regs got id=%0d gcd=%0d err=%b v1=%0d v2=%0d exp all 0",
                               resp_id, resp_gcd, resp_err, gcd_v1, gcd_v2);
        end
    endtask

    task automatic test_single();
        logic [N-1:0] g; int lat, loads; logic [1:0] id; logic [W-1:0] r; logic e;
        do_job(0, 12, 8, g, lat, loads, id, r, e);
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL single_grant got %b exp 0001", g); end
        checks++; if (loads !== 1) begin errors++; $display("FAIL single_loads got %0d exp 1", loads); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL single_latency got %0d exp 6", lat); end
        checks++; if ({id, r, e} !== {2'd0, 16'd4, 1'b0}) begin
            errors++; $display("FAIL single_result got id=%0d gcd=%0d err=%b exp id=0 gcd=4 err=0", id, r, e);
        end
    endtask

    task automatic test_round_robin();
        int unsigned a_tab[4] = '{6, 9, 7, 10};
        int unsigned b_tab[4] = '{4, 3, 5, 0};
        int grants[$];
        int ids[$];
        int unsigned gcds[$];
        do_reset();
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            v1[i*W +: W] = W'(a_tab[i]);
            v2[i*W +: W] = W'(b_tab[i]);
        end
        req_valid = '1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            #1;
            if (req_ready != '0) begin
                for (int i = 0; i < 4; i++) if (req_ready[i]) grants.push_back(i);
                checks++; if (!$onehot(req_ready)) begin errors++; $display("FAIL rr_onehot got %b exp one-hot", req_ready); end
            end
            if (resp_valid) begin
                ids.push_back(int'(resp_id));
                gcds.push_back(int'(resp_gcd));
                if (gcds.size() == 5) begin
                    req_valid = '0;
                    break;
                end
            end
            @(negedge clock);
        end
        checks++; if (gcds.size() != 5 || grants.size() < 5) begin
            errors++; $display("FAIL rr_count got grants=%0d resps=%0d exp 5", grants.size(), gcds.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (grants[i] != i % 4 || ids[i] != i % 4) begin
                    errors++; $display("FAIL rr_order[%0d] got grant=%0d id=%0d exp %0d", i, grants[i], ids[i], i % 4);
                end
                checks++; if (gcds[i] != ref_gcd(a_tab[i%4], b_tab[i%4])) begin
                    errors++; $display("FAIL rr_gcd[%0d] got %0d exp %0d", i, gcds[i], ref_gcd(a_tab[i%4], b_tab[i%4]));
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_bypass();
        logic [N-1:0] g; int lat, loads; logic [1:0] id; logic [W-1:0] r; logic e;
        do_job(1, 0, 9, g, lat, loads, id, r, e);
        checks++; if ({lat, loads, r, e} !== {32'd1, 32'd0, 16'd9, 1'b0}) begin
            errors++; $display("FAIL bypass_0_9 got lat=%0d loads=%0d gcd=%0d err=%b exp lat=1 loads=0 gcd=9 err=0", lat, loads, r, e);
        end
        do_job(2, 5, 0, g, lat, loads, id, r, e);
        checks++; if ({lat, loads, r, e} !== {32'd3, 32'd1, 16'd5, 1'b0}) begin
            errors++; $display("FAIL b_zero_5_0 got lat=%0d loads=%0d gcd=%0d err=%b exp lat=3 loads=1 gcd=5 err=0", lat, loads, r, e);
        end
        do_job(3, 0, 0, g, lat, loads, id, r, e);
        checks++; if ({lat, loads, id, r, e} !== {32'd1, 32'd0, 2'd3, 16'd0, 1'b0}) begin
            errors++; $display("FAIL bypass_0_0 got lat=%0d loads=%0d id=%0d gcd=%0d err=%b exp lat=1 loads=0 id=3 gcd=0 err=0", lat, loads, id, r, e);
        end
    endtask

    task automatic test_timeout();
        logic [N-1:0] g; int lat, loads; logic [1:0] id; logic [W-1:0] r; logic e;
        do_job(0, 7, 1, g, lat, loads, id, r, e);
        checks++; if ({lat, r, e} !== {32'd10, 16'd1, 1'b0}) begin
            errors++; $display("FAIL edge_7_1 got lat=%0d gcd=%0d err=%b exp lat=10 gcd=1 err=0", lat, r, e);
        end
        do_job(1, 8, 1, g, lat, loads, id, r, e);
        checks++; if ({lat, r, e} !== {32'd10, 16'd0, 1'b1}) begin
            errors++; $display("FAIL edge_8_1 got lat=%0d gcd=%0d err=%b exp lat=10 gcd=0 err=1", lat, r, e);
        end
        stall = 1'b1;
        do_job(2, 12, 8, g, lat, loads, id, r, e);
        checks++; if ({lat, loads, id, r, e} !== {32'd10, 32'd1, 2'd2, 16'd0, 1'b1}) begin
            errors++; $display("FAIL stall_timeout got lat=%0d loads=%0d id=%0d gcd=%0d err=%b exp lat=10 loads=1 id=2 gcd=0 err=1", lat, loads, id, r, e);
        end
        stall = 1'b0;
        do_job(3, 12, 8, g, lat, loads, id, r, e);
        checks++; if ({lat, id, r, e} !== {32'd6, 2'd3, 16'd4, 1'b0}) begin
            errors++; $display("FAIL after_timeout got lat=%0d id=%0d gcd=%0d err=%b exp lat=6 id=3 gcd=4 err=0", lat, id, r, e);
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        @(negedge clock);
        resp_ready   = 1'b0;
        v1[1*W +: W] = 16'd9;
        v2[1*W +: W] = 16'd3;
        req_valid[1] = 1'b1;
        @(posedge clock);
        #1;
        req_valid[1] = 1'b0;
        v1[0*W +: W] = 16'd10;
        v2[0*W +: W] = 16'd4;
        req_valid[0] = 1'b1;
        n = 0;
        while (!resp_valid && n < 100) begin @(negedge clock); n++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++; if ({resp_valid, resp_id, resp_gcd, resp_err, req_ready} !== {1'b1, 2'd1, 16'd3, 1'b0, 4'b0000}) begin
                errors++; $display("FAIL hold[%0d] got valid=%b id=%0d gcd=%0d err=%b ready=%b exp 1 1 3 0 0000",
                                   i, resp_valid, resp_id, resp_gcd, resp_err, req_ready);
            end
        end
        resp_ready = 1'b1;
        @(negedge clock);
        checks++; if ({resp_valid, req_ready} !== {1'b0, 4'b0001}) begin
            errors++; $display("FAIL after_accept got valid=%b ready=%b exp valid=0 ready=0001", resp_valid, req_ready);
        end
        @(posedge clock);
        #1 req_valid[0] = 1'b0;
        n = 0;
        while (!resp_valid && n < 100) begin @(negedge clock); n++; end
        checks++; if ({resp_valid, resp_id, resp_gcd} !== {1'b1, 2'd0, 16'd2}) begin
            errors++; $display("FAIL pending_job got valid=%b id=%0d gcd=%0d exp 1 0 2", resp_valid, resp_id, resp_gcd);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g; int lat, loads, n; logic [1:0] id; logic [W-1:0] r; logic e;
        do_job(2, 12, 8, g, lat, loads, id, r, e);
        @(negedge clock);
        v1[2*W +: W] = 16'd15;
        v2[2*W +: W] = 16'd1;
        req_valid[2] = 1'b1;
        @(posedge clock);
        #1 req_valid[2] = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if ({resp_valid, loading, req_ready, resp_id, resp_gcd, resp_err, gcd_v1, gcd_v2} !== '0) begin
            errors++; $display("FAIL mid_reset got valid=%b load=%b ready=%b id=%0d gcd=%0d err=%b v1=%0d v2=%0d exp all 0",
                               resp_valid, loading, req_ready, resp_id, resp_gcd, resp_err, gcd_v1, gcd_v2);
        end
        reset        = 1'b0;
        v1[2*W +: W] = 16'd12;
        v2[2*W +: W] = 16'd8;
        v1[3*W +: W] = 16'd6;
        v2[3*W +: W] = 16'd4;
        req_valid    = 4'b1100;
        #1;
        checks++; if ({resp_valid, req_ready} !== {1'b0, 4'b0100}) begin
            errors++; $display("FAIL post_reset_grant got valid=%b ready=%b exp valid=0 ready=0100", resp_valid, req_ready);
        end
        @(posedge clock);
        #1 req_valid = '0;
        n = 0;
        while (!resp_valid && n < 100) begin @(negedge clock); n++; end
        checks++; if ({resp_valid, resp_id, resp_gcd, resp_err} !== {1'b1, 2'd2, 16'd4, 1'b0}) begin
            errors++; $display("FAIL post_reset_job got valid=%b id=%0d gcd=%0d err=%b exp 1 2 4 0", resp_valid, resp_id, resp_gcd, resp_err);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_random();
        logic [N-1:0] g; int lat, loads; logic [1:0] id; logic [W-1:0] r; logic e;
        int unsigned a, b, eg; logic ee; int elat, eloads; int idx;
        for (int t = 0; t < 40; t++) begin
            idx = int'($urandom_range(0, N - 1));
            a   = $urandom_range(0, 24);
            b   = $urandom_range(0, 24);
            if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 65535);
            ref_model(a, b, eg, ee, elat, eloads);
            do_job(idx, a, b, g, lat, loads, id, r, e);
            checks++; if ({g, lat, loads} !== {N'(1) << idx, elat, eloads}) begin
                errors++; $display("FAIL rand_timing a=%0d b=%0d got grant=%b lat=%0d loads=%0d exp grant=%b lat=%0d loads=%0d",
                                   a, b, g, lat, loads, N'(1) << idx, elat, eloads);
            end
            checks++; if ({id, r, e} !== {2'(idx), W'(eg), ee}) begin
                errors++; $display("FAIL rand_result a=%0d b=%0d got id=%0d gcd=%0d err=%b exp id=%0d gcd=%0d err=%b",
                                   a, b, id, r, e, idx, eg, ee);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1);
    end

    initial begin
        req_valid  = '0;
        v1         = '0;
        v2         = '0;
        resp_ready = 1'b1;
        stall      = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_bypass();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
